// File: rtl/event_capture.sv
// Spike-event FIFO with a three-state output handshake toward the convolution engine.
// Optional build macro EVENT_CAPTURE_MERGE_EN merges same-coordinate events into the FIFO tail.
module event_capture #(
  parameter int COORD_BITS  = 6,
  parameter int IN_CHANNELS = 4,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [COORD_BITS-1:0]                 in_x,
  input  logic [COORD_BITS-1:0]                 in_y,
  input  logic [IN_CHANNELS-1:0]                in_spikes,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [2*COORD_BITS+IN_CHANNELS-1:0]   event_out,
  output logic                                  event_valid,
  input  logic                                  event_ack,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
  output logic [15:0]                           drop_count,
  output logic                                  busy
);

  localparam int EV_W  = 2*COORD_BITS + IN_CHANNELS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [COORD_BITS:0] LIM_X = (COORD_BITS+1)'(IMG_WIDTH);
  localparam logic [COORD_BITS:0] LIM_Y = (COORD_BITS+1)'(IMG_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

  logic [EV_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_drop_count;
  logic [EV_W-1:0]  r_event_out;
  logic             r_event_valid;
  state_t           r_state;

  logic             w_accept, w_drop, w_keep, w_pop, w_push;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_addr;
  logic [EV_W-1:0]  w_wr_data, w_in_ev;

  assign w_in_ev  = {in_x, in_y, in_spikes};
  assign in_ready = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && (({1'b0, in_x} >= LIM_X) || ({1'b0, in_y} >= LIM_Y) ||
                                 (in_spikes == '0));
  assign w_keep   = w_accept && !w_drop;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);

`ifdef EVENT_CAPTURE_MERGE_EN
  // Shadow of the last written entry so the tail compare needs no asynchronous RAM read.
  logic [EV_W-1:0] r_tail;
  logic            w_merge;
  assign w_merge = w_keep &&
                   ((r_count > CNT_W'(1)) || ((r_count == CNT_W'(1)) && !w_pop)) &&
                   (r_tail[EV_W-1:IN_CHANNELS] == w_in_ev[EV_W-1:IN_CHANNELS]);
  assign w_push    = w_keep && !w_merge;
  assign w_wr_en   = w_keep;
  assign w_wr_addr = w_merge ? (r_wr_ptr - PTR_W'(1)) : r_wr_ptr;
  assign w_wr_data = w_merge ? {r_tail[EV_W-1:IN_CHANNELS], r_tail[IN_CHANNELS-1:0] | in_spikes}
                             : w_in_ev;

  always_ff @(posedge clk) begin
    if (rst)          r_tail <= '0;
    else if (w_wr_en) r_tail <= w_wr_data;
  end
`else
  assign w_push    = w_keep;
  assign w_wr_en   = w_keep;
  assign w_wr_addr = r_wr_ptr;
  assign w_wr_data = w_in_ev;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // GAP forces one low cycle of event_valid after every acknowledged event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_event_out   <= '0;
      r_event_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_event_out   <= r_mem[r_rd_ptr];
            r_event_valid <= 1'b1;
            r_state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (event_ack) begin
            r_event_valid <= 1'b0;
            r_state       <= S_GAP;
          end
        end
        S_GAP: begin
          r_event_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_event_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign event_out   = r_event_out;
  assign event_valid = r_event_valid;
  assign fifo_count  = r_count;
  assign drop_count  = r_drop_count;
  assign busy        = r_event_valid || (r_count != '0);

endmodule

// File: tb/tb_event_capture.sv
// Randomized and directed bench for event_capture against a queue-based transaction model.
module tb_event_capture;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [3:0] s;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  in_x, in_y;
  logic [3:0]  in_spikes;
  logic        in_valid, in_ready;
  logic [15:0] event_out;
  logic        event_valid, event_ack;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;
  logic        busy;

  event_capture #(
    .COORD_BITS(6), .IN_CHANNELS(4), .IMG_WIDTH(32), .IMG_HEIGHT(32), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_spikes(in_spikes),
    .in_valid(in_valid), .in_ready(in_ready), .event_out(event_out),
    .event_valid(event_valid), .event_ack(event_ack), .fifo_count(fifo_count),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: pending events, the event on offer downstream, and a one-cycle cool-down after ack.
  ev_t mq[$];
  bit  m_valid = 0;
  bit  m_gap = 0;
  ev_t m_data = '0;
  int  m_drop = 0;
  bit  last_acc;
  ev_t src[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input ev_t e, input bit a);
    bit  acc;
    bit  merge_en;
`ifdef EVENT_CAPTURE_MERGE_EN
    merge_en = 1;
`else
    merge_en = 0;
`endif
    last_acc = 0;
    if (r) begin
      mq.delete();
      m_valid = 0; m_gap = 0; m_data = '0; m_drop = 0;
      return;
    end
    acc = v && (mq.size() < 8);
    last_acc = acc;
    if (m_valid) begin
      if (a) begin m_valid = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (mq.size() > 0) begin
      m_data = mq.pop_front();
      m_valid = 1;
    end
    if (acc) begin
      if (e.x >= 32 || e.y >= 32 || e.s == 0) begin
        if (m_drop < 65535) m_drop++;
      end else if (merge_en && mq.size() > 0 &&
                   mq[mq.size()-1].x == e.x && mq[mq.size()-1].y == e.y) begin
        mq[mq.size()-1].s = mq[mq.size()-1].s | e.s;
      end else begin
        mq.push_back(e);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input ev_t e, input bit a);
    rst = r; in_valid = v; {in_x, in_y, in_spikes} = e; event_ack = a;
    @(posedge clk);
    model_step(r, v, e, a);
    @(negedge clk);
    chk("in_ready",    in_ready,    mq.size() < 8);
    chk("fifo_count",  fifo_count,  mq.size());
    chk("drop_count",  drop_count,  m_drop);
    chk("event_valid", event_valid, m_valid);
    chk("busy",        busy,        m_valid || mq.size() != 0);
    chk("event_out",   event_out,   m_data);
  endtask

  // ack_mode: 0 never, 1 whenever an event is on offer, 2 random
  task automatic run(input int cycles, input int ack_mode);
    ev_t e;
    bit  v, a;
    for (int i = 0; i < cycles; i++) begin
      v = (src.size() > 0);
      e = v ? src[0] : '0;
      a = (ack_mode == 1) ? m_valid : (ack_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      cyc(0, v, e, a);
      if (last_acc) void'(src.pop_front());
    end
  endtask

  function automatic ev_t rnd_ev();
    ev_t e;
    e.x = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 3));
    e.y = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 3));
    e.s = 4'($urandom_range(0, 15));
    return e;
  endfunction

  initial begin
    rst = 1; in_valid = 0; in_x = 0; in_y = 0; in_spikes = 0; event_ack = 0;
    cyc(1, 0, '0, 0);
    cyc(1, 0, '0, 0);

    // single event, ack withheld
    src.push_back('{x: 6'd3, y: 6'd5, s: 4'b0101});
    run(7, 0);
    run(6, 1);

    // backpressure: 10 distinct events, no ack, then one ack, then drain
    for (int i = 0; i < 10; i++) src.push_back('{x: 6'(i), y: 6'(i + 1), s: 4'(i % 15 + 1)});
    run(14, 0);
    cyc(0, src.size() > 0, src.size() > 0 ? src[0] : '0, 1);
    if (last_acc) void'(src.pop_front());
    run(4, 0);
    run(45, 1);

    // drops
    src.push_back('{x: 6'd32, y: 6'd0, s: 4'b0001});
    src.push_back('{x: 6'd1,  y: 6'd1, s: 4'b0000});
    run(6, 0);

    // merge candidates behind a busy output register
    src.push_back('{x: 6'd9, y: 6'd9, s: 4'b1000});
    run(3, 0);
    src.push_back('{x: 6'd4, y: 6'd4, s: 4'b0001});
    src.push_back('{x: 6'd4, y: 6'd4, s: 4'b0010});
    run(4, 0);
    run(15, 1);

    // reset mid-operation, then acks with nothing to consume
    for (int i = 0; i < 4; i++) src.push_back('{x: 6'(10 + i), y: 6'd2, s: 4'b0110});
    run(6, 0);
    cyc(1, 0, '0, 0);
    src.delete();
    run(4, 1);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);

    // wrap-around stream
    for (int i = 0; i < 20; i++) src.push_back('{x: 6'(i % 32), y: 6'(31 - i), s: 4'(i % 15 + 1)});
    run(90, 1);

    // random traffic with occasional reset
    for (int i = 0; i < 2500; i++) begin
      ev_t e;
      e = rnd_ev();
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, e,
          $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
